// File: rtl/mux_scan_pkg.sv
// Shared types and sizes for the 16-channel mux scan sequencer.
package mux_scan_pkg;
  localparam int NUM_CH = 16;
  localparam int SEL_W  = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE
  } scan_state_e;
endpackage

// File: rtl/mux_16x1.sv
// 16-to-1 multiplexer that the sequencer scans; select s picks input d[s].
module mux_16x1 (
  input  logic [15:0] d,
  input  logic [3:0]  s,
  output logic        y
);
  assign y = d[s];
endmodule

// File: rtl/scan_settle_cnt.sv
// Loadable down-counter that times the settle interval after each select change.
module scan_settle_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         tc
);
  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);
endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps the mux select through all channels, waits SETTLE cycles per channel,
// samples y_in and publishes each completed sweep as one word with a valid pulse.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        cont,
  input  logic        abort,
  input  logic        y_in,
  output logic [3:0]  sel,
  output logic [15:0] data_out,
  output logic        valid,
  output logic        busy
);
  // With no settle time every channel goes straight to its sample cycle.
  localparam scan_state_e CH_STATE = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = (SETTLE == 0) ? '0 : CNT_W'(SETTLE - 1);
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_CH - 1);

  scan_state_e       state;
  logic [NUM_CH-2:0] shadow;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_tc;
  logic [CNT_W-1:0]  cnt_val;
  logic              last_ch;

  assign last_ch = (sel == LAST_SEL);

  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = SETTLE_LOAD;
    if (abort) begin
      cnt_load = 1'b1;
      cnt_val  = '0;
    end else begin
      case (state)
        ST_IDLE:   cnt_load = start;
        ST_SETTLE: cnt_dec  = !cnt_tc;
        ST_SAMPLE: begin
          cnt_load = 1'b1;
          if (last_ch && !cont) cnt_val = '0;
        end
        default:   cnt_load = 1'b0;
      endcase
    end
  end

  scan_settle_cnt #(.W(CNT_W)) u_settle_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sel      <= '0;
      shadow   <= '0;
      data_out <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else if (abort) begin
      state  <= ST_IDLE;
      sel    <= '0;
      shadow <= '0;
      valid  <= 1'b0;
      busy   <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= CH_STATE;
            sel   <= '0;
            busy  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt_tc) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          if (!last_ch) begin
            shadow[sel] <= y_in;
            sel         <= sel + 1'b1;
            state       <= CH_STATE;
          end else begin
            // The last channel goes straight into the output word.
            data_out <= {y_in, shadow};
            valid    <= 1'b1;
            sel      <= '0;
            state    <= cont ? CH_STATE : ST_IDLE;
            busy     <= cont;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: one instance with SETTLE=1 and one with SETTLE=0, each scanning a mux_16x1.
module tb_mux_scan_ctrl;
  localparam int P1 = 32;
  localparam int P0 = 16;

  logic clk = 1'b0;
  logic rst;
  logic start1, cont1, abort1, y1, valid1, busy1;
  logic [3:0]  sel1;
  logic [15:0] di1, data1;
  logic start0, cont0, abort0, y0, valid0, busy0;
  logic [3:0]  sel0;
  logic [15:0] di0, data0;

  int cyc = 0;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  mux_16x1 u_mux1 (.d(di1), .s(sel1), .y(y1));
  mux_scan_ctrl #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .cont(cont1), .abort(abort1), .y_in(y1),
    .sel(sel1), .data_out(data1), .valid(valid1), .busy(busy1)
  );

  mux_16x1 u_mux0 (.d(di0), .s(sel0), .y(y0));
  mux_scan_ctrl #(.SETTLE(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .cont(cont0), .abort(abort0), .y_in(y0),
    .sel(sel0), .data_out(data0), .valid(valid0), .busy(busy0)
  );

  // Driver: pulse start for one cycle; e0 is the index of the edge that samples it.
  task automatic start_sweep(input bit which, output int e0);
    @(posedge clk); #1;
    if (which) start1 = 1'b1; else start0 = 1'b1;
    e0 = cyc + 1;
    @(posedge clk); #1;
    start1 = 1'b0;
    start0 = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (sel1 !== 4'h0) begin fails++; $display("FAIL reset_sel1: got %h want 0", sel1); end
    tests++; if (data1 !== 16'h0) begin fails++; $display("FAIL reset_data1: got %h want 0", data1); end
    tests++; if (valid1 !== 1'b0) begin fails++; $display("FAIL reset_valid1: got %b want 0", valid1); end
    tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL reset_busy1: got %b want 0", busy1); end
    tests++; if (data0 !== 16'h0) begin fails++; $display("FAIL reset_data0: got %h want 0", data0); end
    tests++; if (busy0 !== 1'b0) begin fails++; $display("FAIL reset_busy0: got %b want 0", busy0); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single_sweep(input logic [15:0] di);
    int e0, rel, nv, vrel, busy_bad;
    logic [15:0] vdat;
    di1 = di; cont1 = 1'b0;
    nv = 0; vrel = -1; vdat = '0; busy_bad = 0;
    start_sweep(1'b1, e0);
    for (int i = 0; i < P1 + 8; i++) begin
      @(negedge clk);
      rel = cyc - e0;
      if (valid1) begin nv++; vrel = rel; vdat = data1; end
      if (busy1 !== (rel < P1)) busy_bad++;
    end
    tests++; if (nv != 1) begin fails++; $display("FAIL single_valid_count: got %0d want 1", nv); end
    tests++; if (vrel != P1) begin fails++; $display("FAIL single_valid_cycle: got %0d want %0d", vrel, P1); end
    tests++; if (vdat !== di) begin fails++; $display("FAIL single_data: got %h want %h", vdat, di); end
    tests++; if (busy_bad != 0) begin fails++; $display("FAIL single_busy: got %0d bad cycles want 0", busy_bad); end
  endtask

  task automatic test_settle0(input logic [15:0] di);
    int e0, rel, nv, vrel, sel_bad;
    logic [15:0] vdat;
    logic [3:0] exp_sel;
    di0 = di; cont0 = 1'b0;
    nv = 0; vrel = -1; vdat = '0; sel_bad = 0;
    start_sweep(1'b0, e0);
    for (int i = 0; i < P0 + 6; i++) begin
      @(negedge clk);
      rel = cyc - e0;
      exp_sel = (rel < P0) ? 4'(rel) : 4'h0;
      if (sel0 !== exp_sel) sel_bad++;
      if (valid0) begin nv++; vrel = rel; vdat = data0; end
    end
    tests++; if (nv != 1) begin fails++; $display("FAIL s0_valid_count: got %0d want 1", nv); end
    tests++; if (vrel != P0) begin fails++; $display("FAIL s0_valid_cycle: got %0d want %0d", vrel, P0); end
    tests++; if (vdat !== di) begin fails++; $display("FAIL s0_data: got %h want %h", vdat, di); end
    tests++; if (sel_bad != 0) begin fails++; $display("FAIL s0_sel_steps: got %0d bad cycles want 0", sel_bad); end
  endtask

  task automatic test_continuous(input int n, input logic [15:0] words [4]);
    int e0, rel, off, busy_bad;
    int got_rel[$];
    logic [15:0] got_dat[$];
    logic [15:0] exp_q[$];
    off = $urandom_range(P1 - 1, 1);
    busy_bad = 0;
    for (int k = 0; k < n; k++) exp_q.push_back(words[k]);
    di1 = words[0]; cont1 = 1'b1;
    start_sweep(1'b1, e0);
    for (int i = 0; i < n * P1 + 8; i++) begin
      @(negedge clk);
      rel = cyc - e0;
      if (valid1) begin got_rel.push_back(rel); got_dat.push_back(data1); end
      if (busy1 !== (rel < n * P1)) busy_bad++;
      // Next sweep's word goes on the mux between the last and first sample edges.
      if (rel > 0 && rel % P1 == 0 && rel / P1 < n) di1 = words[rel / P1];
      if (rel == (n - 1) * P1 + off) cont1 = 1'b0;
    end
    tests++; if (got_rel.size() != n) begin fails++; $display("FAIL cont_valid_count: got %0d want %0d", got_rel.size(), n); end
    for (int k = 0; k < n && k < got_rel.size(); k++) begin
      tests++; if (got_rel[k] != (k + 1) * P1) begin fails++; $display("FAIL cont_valid_cycle[%0d]: got %0d want %0d", k, got_rel[k], (k + 1) * P1); end
      tests++; if (got_dat[k] !== exp_q[k]) begin fails++; $display("FAIL cont_data[%0d]: got %h want %h", k, got_dat[k], exp_q[k]); end
    end
    tests++; if (busy_bad != 0) begin fails++; $display("FAIL cont_busy: got %0d bad cycles want 0", busy_bad); end
  endtask

  task automatic test_abort(input int r, input logic [15:0] pre, input logic [15:0] di);
    int e0, rel, nv, busy_bad;
    test_single_sweep(pre);
    di1 = di; nv = 0; busy_bad = 0;
    start_sweep(1'b1, e0);
    for (int i = 0; i < P1 + 8; i++) begin
      @(negedge clk);
      rel = cyc - e0;
      if (valid1) nv++;
      if (busy1 !== (rel <= r)) busy_bad++;
      if (rel == r + 1) begin
        abort1 = 1'b0;
        tests++; if (sel1 !== 4'h0) begin fails++; $display("FAIL abort_sel: got %h want 0", sel1); end
      end
      if (rel == r) abort1 = 1'b1;
    end
    tests++; if (nv != 0) begin fails++; $display("FAIL abort_valid_count: got %0d want 0", nv); end
    tests++; if (data1 !== pre) begin fails++; $display("FAIL abort_data_kept: got %h want %h", data1, pre); end
    tests++; if (busy_bad != 0) begin fails++; $display("FAIL abort_busy: got %0d bad cycles want 0", busy_bad); end
  endtask

  task automatic test_start_abort_idle();
    int nv, busy_seen;
    nv = 0; busy_seen = 0;
    @(posedge clk); #1;
    start1 = 1'b1; abort1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; abort1 = 1'b0;
    for (int i = 0; i < P1 + 4; i++) begin
      @(negedge clk);
      if (valid1) nv++;
      if (busy1 !== 1'b0) busy_seen++;
    end
    tests++; if (busy_seen != 0) begin fails++; $display("FAIL start_abort_busy: got %0d busy cycles want 0", busy_seen); end
    tests++; if (nv != 0) begin fails++; $display("FAIL start_abort_valid: got %0d want 0", nv); end
  endtask

  task automatic test_reset_mid();
    int e0, rel;
    di1 = 16'($urandom);
    start_sweep(1'b1, e0);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      rel = cyc - e0;
      if (rel == 21) begin
        rst = 1'b0;
        tests++; if (sel1 !== 4'h0) begin fails++; $display("FAIL rstmid_sel: got %h want 0", sel1); end
        tests++; if (data1 !== 16'h0) begin fails++; $display("FAIL rstmid_data: got %h want 0", data1); end
        tests++; if (valid1 !== 1'b0) begin fails++; $display("FAIL rstmid_valid: got %b want 0", valid1); end
        tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", busy1); end
      end
      if (rel == 4) start1 = 1'b1;
      if (rel == 5) start1 = 1'b0;
      if (rel == 20) rst = 1'b1;
    end
    repeat (2) @(posedge clk);
    test_single_sweep(16'($urandom));
  endtask

  task automatic test_start_while_busy();
    int e0, rel, nv, vrel;
    di1 = 16'($urandom); cont1 = 1'b0;
    nv = 0; vrel = -1;
    start_sweep(1'b1, e0);
    for (int i = 0; i < P1 + 40; i++) begin
      @(negedge clk);
      rel = cyc - e0;
      if (valid1) begin nv++; vrel = rel; end
      start1 = (rel == 2 || rel == 14);
    end
    tests++; if (nv != 1) begin fails++; $display("FAIL busy_start_count: got %0d want 1", nv); end
    tests++; if (vrel != P1) begin fails++; $display("FAIL busy_start_cycle: got %0d want %0d", vrel, P1); end
  endtask

  // Mux inputs change every cycle; each bit must come from the value present at its own sample edge.
  task automatic test_random_sweep();
    int e0, rel, nv;
    logic [15:0] hist [P1];
    logic [15:0] exp_w, vdat;
    nv = 0; vdat = '0; cont1 = 1'b0;
    start_sweep(1'b1, e0);
    for (int i = 0; i < P1 + 4; i++) begin
      @(negedge clk);
      rel = cyc - e0;
      if (valid1) begin nv++; vdat = data1; end
      if (rel < P1) begin di1 = 16'($urandom); hist[rel] = di1; end
    end
    for (int k = 0; k < 16; k++) exp_w[k] = hist[(k + 1) * 2 - 1][k];
    tests++; if (nv != 1) begin fails++; $display("FAIL rand_valid_count: got %0d want 1", nv); end
    tests++; if (vdat !== exp_w) begin fails++; $display("FAIL rand_data: got %h want %h", vdat, exp_w); end
  endtask

  initial begin
    logic [15:0] w [4];
    rst = 1'b1;
    start1 = 1'b0; cont1 = 1'b0; abort1 = 1'b0; di1 = '0;
    start0 = 1'b0; cont0 = 1'b0; abort0 = 1'b0; di0 = '0;

    test_reset();
    test_single_sweep(16'hA5C3);
    test_single_sweep(16'($urandom));
    test_settle0(16'h0001);
    test_settle0(16'($urandom));
    w = '{16'hFFFF, 16'h1234, 16'h0000, 16'h0000};
    test_continuous(2, w);
    w = '{16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom)};
    test_continuous(int'($urandom_range(4, 3)), w);
    test_abort(10, 16'hA5C3, 16'h5555);
    test_abort(int'($urandom_range(31, 0)), 16'($urandom), 16'($urandom));
    test_single_sweep(16'($urandom));
    test_start_abort_idle();
    test_reset_mid();
    test_start_while_busy();
    repeat (3) test_random_sweep();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
